mips_cpu_hilo_muldiv: RTL and testbench

Multi-cycle multiply/divide unit that owns the architectural HI/LO registers of the MIPS CPU. It accepts mult, multu, div, divu, mthi and mtlo requests from the execute stage and serves mfhi/mflo reads back to it. It raises a stall while an iterative operation is in flight, so single-cycle execute logic never has to hold 64-bit arithmetic.

---
 rtl/mips_cpu_hilo_muldiv.sv | 167 ++++++++++++++++
 tb/tb_mips_cpu_hilo_muldiv.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_hilo_muldiv.sv
// HI/LO owner for the MIPS core: iterative shift-add multiply and restoring divide.
// Define MIPS_HILO_FAST_MULT_EN for a single-cycle multiply (divide stays iterative).
module mips_cpu_hilo_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             mfhi,
  input  logic             mflo,
  output logic [WIDTH-1:0] rd_data,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [2:0] OP_MULT = 3'b000, OP_MULTU = 3'b001, OP_DIV  = 3'b010,
                         OP_DIVU = 3'b011, OP_MTHI  = 3'b100, OP_MTLO = 3'b101;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]     a_q, a_d;          // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0]   acc_q, acc_d;      // {partial hi, multiplier} or {remainder, quotient}
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 neg_q, neg_d, rneg_q, rneg_d, isdiv_q, isdiv_d, done_q, done_d;

  logic                 sgn, rs_neg, rt_neg;
  logic [WIDTH-1:0]     rs_mag, rt_mag;
  logic [WIDTH:0]       mul_sum, div_sh;
  logic [WIDTH-1:0]     div_diff, div_rem;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   mul_next, div_next;

  // op[0] clear means signed; |-2^31| wraps to itself and is read as unsigned
  assign sgn    = ~op[0];
  assign rs_neg = sgn & rs_data[WIDTH-1];
  assign rt_neg = sgn & rt_data[WIDTH-1];
  assign rs_mag = rs_neg ? -rs_data : rs_data;
  assign rt_mag = rt_neg ? -rt_data : rt_data;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? a_q : '0)};
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  assign div_sh   = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_ge   = div_sh >= {1'b0, a_q};
  assign div_diff = div_sh[WIDTH-1:0] - a_q;
  assign div_rem  = div_ge ? div_diff : div_sh[WIDTH-1:0];
  assign div_next = {div_rem, acc_q[WIDTH-2:0], div_ge};

`ifdef MIPS_HILO_FAST_MULT_EN
  logic [2*WIDTH-1:0] fast_mag, fast_prod;
  assign fast_mag  = {{WIDTH{1'b0}}, rs_mag} * {{WIDTH{1'b0}}, rt_mag};
  assign fast_prod = (rs_neg ^ rt_neg) ? -fast_mag : fast_mag;
`endif

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    isdiv_d = isdiv_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        case (op)
          OP_MTHI: hi_d = rs_data;
          OP_MTLO: lo_d = rs_data;
          OP_MULT, OP_MULTU: begin
`ifdef MIPS_HILO_FAST_MULT_EN
            {hi_d, lo_d} = fast_prod;
            done_d       = 1'b1;
`else
            a_d     = rs_mag;
            acc_d   = {{WIDTH{1'b0}}, rt_mag};
            neg_d   = rs_neg ^ rt_neg;
            isdiv_d = 1'b0;
            cnt_d   = '0;
            state_d = MUL;
`endif
          end
          OP_DIV, OP_DIVU: begin
            isdiv_d = 1'b1;
            cnt_d   = '0;
            if (rt_data == '0) begin
              acc_d   = {rs_data, {WIDTH{1'b1}}};
              neg_d   = 1'b0;
              rneg_d  = 1'b0;
              state_d = FIX;
            end else begin
              a_d     = rt_mag;
              acc_d   = {{WIDTH{1'b0}}, rs_mag};
              neg_d   = rs_neg ^ rt_neg;
              rneg_d  = rs_neg;
              state_d = DIV;
            end
          end
          default: ;
        endcase
      end
      MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
      end
      DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
      end
      FIX: begin
        if (isdiv_q) begin
          lo_d = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
          hi_d = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end else begin
          {hi_d, lo_d} = neg_q ? -acc_q : acc_q;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      isdiv_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      isdiv_q <= isdiv_d;
      done_q  <= done_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign stall   = busy & (start | mfhi | mflo);
  assign done    = done_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign rd_data = mfhi ? hi_q : (mflo ? lo_q : '0);
endmodule

// File: tb/tb_mips_cpu_hilo_muldiv.sv
// Directed bench for mips_cpu_hilo_muldiv; honours MIPS_HILO_FAST_MULT_EN for multiply latency.
module tb_mips_cpu_hilo_muldiv;
  logic        clk, reset, start, mfhi, mflo;
  logic [2:0]  op;
  logic [31:0] rs_data, rt_data, rd_data, hi, lo;
  logic        stall, busy, done;
  int          total = 0, bad = 0, n;

`ifdef MIPS_HILO_FAST_MULT_EN
  localparam int MUL_CYC = 0;
`else
  localparam int MUL_CYC = 33;
`endif

  mips_cpu_hilo_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs_data(rs_data), .rt_data(rt_data),
    .mfhi(mfhi), .mflo(mflo), .rd_data(rd_data), .stall(stall), .busy(busy), .done(done),
    .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // issue one request, then count the cycles busy stays high (bounded)
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int cyc);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    tick();
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd0; rs_data = '0; rt_data = '0; mfhi = 1'b0; mflo = 1'b0;
    tick(); tick();
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_rd", rd_data, 32'h0);
    reset = 1'b0;
    tick();

    run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, n);
    chk("multu_cyc", n, MUL_CYC);
    chk("multu_done", {31'd0, done}, 32'd1);
    chk("multu_hi", hi, 32'hFFFFFFFE);
    chk("multu_lo", lo, 32'h00000001);
    tick();
    chk("multu_done_pulse", {31'd0, done}, 32'd0);

    run_op(3'b000, 32'hFFFFFFFD, 32'd5, n);
    chk("mult_cyc", n, MUL_CYC);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFF1);

    run_op(3'b010, 32'hFFFFFFF9, 32'd2, n);
    chk("div_cyc", n, 33);
    chk("div_done", {31'd0, done}, 32'd1);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);

    run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, n);
    chk("divmin_lo", lo, 32'h80000000);
    chk("divmin_hi", hi, 32'h0);

    run_op(3'b011, 32'd7, 32'd0, n);
    chk("divz_cyc", n, 1);
    chk("divz_done", {31'd0, done}, 32'd1);
    chk("divz_hi", hi, 32'd7);
    chk("divz_lo", lo, 32'hFFFFFFFF);
    tick();

    // reserved op must not touch HI/LO or go busy
    start = 1'b1; op = 3'b110; rs_data = 32'h11111111;
    tick();
    start = 1'b0;
    chk("rsvd_busy", {31'd0, busy}, 32'd0);
    chk("rsvd_hi", hi, 32'd7);

    // mthi with a same-cycle read returns the old HI
    start = 1'b1; op = 3'b100; rs_data = 32'h12345678; mfhi = 1'b1;
    #1;
    chk("mthi_pre_rd", rd_data, 32'd7);
    tick();
    start = 1'b0;
    #1;
    chk("mthi_rd", rd_data, 32'h12345678);
    chk("mthi_stall", {31'd0, stall}, 32'd0);
    chk("mthi_done", {31'd0, done}, 32'd0);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    mfhi = 1'b0;
    start = 1'b1; op = 3'b101; rs_data = 32'hA5A5A5A5;
    tick();
    start = 1'b0;
    chk("mtlo_lo", lo, 32'hA5A5A5A5);

    // read and ignored start in the middle of a divide
    start = 1'b1; op = 3'b010; rs_data = 32'hFFFFFF9C; rt_data = 32'd7;
    tick();
    start = 1'b0;
    tick(); tick();
    mflo = 1'b1; start = 1'b1; op = 3'b100; rs_data = 32'hDEADBEEF;
    #1;
    chk("mid_stall", {31'd0, stall}, 32'd1);
    chk("mid_rd", rd_data, 32'hA5A5A5A5);
    tick();
    start = 1'b0; mflo = 1'b0;
    n = 3;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk("mid_cyc", n, 33);
    chk("mid_lo", lo, 32'hFFFFFFF2);
    chk("mid_hi", hi, 32'hFFFFFFFE);
    tick();

    // reset during divide iterations aborts with no write
    start = 1'b1; op = 3'b011; rs_data = 32'd1000; rt_data = 32'd3;
    tick();
    start = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    #1;
    chk("abort_hi", hi, 32'h0);
    chk("abort_lo", lo, 32'h0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    tick();
    reset = 1'b0;
    tick(); tick();
    chk("abort_done_late", {31'd0, done}, 32'd0);
    chk("abort_lo_late", lo, 32'h0);

    run_op(3'b011, 32'd100, 32'd7, n);
    chk("divu_cyc", n, 33);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
